// File: rtl/dht_pkg.sv
// Shared definitions for the DHT sensor path: controller state encoding,
// 40-bit frame field positions and default timing constants.
package dht_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_START = 4'b0010,
      ST_WAIT  = 4'b0100,
      ST_GUARD = 4'b1000
   } state_t;

   localparam int FRAME_W  = 40;
   localparam int HUM_MSB  = 39;
   localparam int HUM_LSB  = 24;
   localparam int TEMP_MSB = 23;
   localparam int TEMP_LSB = 8;
   localparam int CSUM_MSB = 7;
   localparam int CSUM_LSB = 0;

   localparam int DEF_PERIOD_CYC  = 200000000;
   localparam int DEF_GUARD_CYC   = 100000000;
   localparam int DEF_TIMEOUT_CYC = 10000000;
   localparam int DEF_MAX_RETRY   = 3;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [15:0] frame_humidity(input logic [FRAME_W-1:0] frame);
      return frame[HUM_MSB:HUM_LSB];
   endfunction

   function automatic logic [15:0] frame_temperature(input logic [FRAME_W-1:0] frame);
      return frame[TEMP_MSB:TEMP_LSB];
   endfunction

endpackage

// File: rtl/dht_interval_timer.sv
// Loadable down-counter: load presets CYC-1, run counts toward zero and stops
// there; done flags the terminal cycle while running.
module dht_interval_timer
   import dht_pkg::*;
#(
   parameter int CYC = DEF_GUARD_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic run,
   output logic done
);

   localparam int W = cnt_w(CYC);
   localparam logic [W-1:0] LOAD_VAL = W'(CYC - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (run && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign done = run && (count == '0);

endmodule

// File: rtl/dht_poll_ctrl.sv
// DHT sensor poll controller: starts reads on host request or periodic tick,
// retries failed reads after a guard interval and holds the last good sample.
module dht_poll_ctrl
   import dht_pkg::*;
#(
   parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
   parameter int GUARD_CYC   = DEF_GUARD_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        req,
   output logic        sensor_start,
   input  logic        sensor_ready,
   input  logic        sensor_error,
   input  logic [39:0] sensor_data,
   output logic [15:0] humidity,
   output logic [15:0] temperature,
   output logic        valid,
   output logic        fail,
   output logic        busy
);

   localparam int RETRY_W = cnt_w(MAX_RETRY + 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

   state_t state, state_nxt;
   logic period_done, guard_done, timeout_done;
   logic trigger, pending;
   logic good_p0, bad_p0;
   logic [RETRY_W-1:0] retry_cnt;
   logic frame_unused;

   // Out of reset the period counter sits at zero; it is preset on the first
   // disabled cycle, so the first tick comes PERIOD_CYC cycles after enable rises.
   dht_interval_timer #(.CYC(PERIOD_CYC)) u_period (
      .clk  (clk),
      .rst  (rst),
      .load (!enable || period_done),
      .run  (enable),
      .done (period_done)
   );

   dht_interval_timer #(.CYC(GUARD_CYC)) u_guard (
      .clk  (clk),
      .rst  (rst),
      .load (state == ST_WAIT),
      .run  (state == ST_GUARD),
      .done (guard_done)
   );

   dht_interval_timer #(.CYC(TIMEOUT_CYC)) u_timeout (
      .clk  (clk),
      .rst  (rst),
      .load (state == ST_START),
      .run  (state == ST_WAIT),
      .done (timeout_done)
   );

   assign trigger      = req || period_done;
   assign frame_unused = ^sensor_data[CSUM_MSB:CSUM_LSB];

   // A ready strobe beats a timeout landing on the same WAIT cycle.
   assign good_p0 = (state == ST_WAIT) && sensor_ready && !sensor_error;
   assign bad_p0  = (state == ST_WAIT) &&
                    ((sensor_ready && sensor_error) || (!sensor_ready && timeout_done));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (trigger || pending) state_nxt = ST_START;
         ST_START: state_nxt = ST_WAIT;
         ST_WAIT:  if (sensor_ready || timeout_done) state_nxt = ST_GUARD;
         ST_GUARD: if (guard_done) state_nxt = (retry_cnt != '0) ? ST_START : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Retry owed is simply a non-zero retry count while in GUARD.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         pending   <= 1'b0;
         retry_cnt <= '0;
         fail      <= 1'b0;
         valid     <= 1'b0;
      end else begin
         state <= state_nxt;
         valid <= good_p0;
         if (trigger && (state != ST_IDLE)) begin
            pending <= 1'b1;
         end else if ((state == ST_IDLE) && (state_nxt == ST_START)) begin
            pending <= 1'b0;
         end
         if (good_p0) begin
            retry_cnt <= '0;
            fail      <= 1'b0;
         end else if (bad_p0) begin
            if (retry_cnt == RETRY_LAST) begin
               retry_cnt <= '0;
               fail      <= 1'b1;
            end else begin
               retry_cnt <= retry_cnt + RETRY_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         humidity    <= '0;
         temperature <= '0;
      end else if (good_p0) begin
         humidity    <= frame_humidity(sensor_data);
         temperature <= frame_temperature(sensor_data);
      end
   end

   assign sensor_start = (state == ST_START);
   assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_dht_poll_ctrl.sv
// Bench for dht_poll_ctrl: directed scenarios, a sensor responder and a
// transaction-timeline reference model compared every cycle.
`timescale 1ns/1ps
module tb_dht_poll_ctrl;

   localparam int PERIOD = 1000;
   localparam int GUARD  = 100;
   localparam int TOUT   = 200;
   localparam int RETRY  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        req = 1'b0;
   logic        sensor_ready = 1'b0;
   logic        sensor_error = 1'b0;
   logic [39:0] sensor_data = '0;
   logic        sensor_start, valid, fail, busy;
   logic [15:0] humidity, temperature;

   always #5 clk = ~clk;

   dht_poll_ctrl #(
      .PERIOD_CYC  (PERIOD),
      .GUARD_CYC   (GUARD),
      .TIMEOUT_CYC (TOUT),
      .MAX_RETRY   (RETRY)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .req          (req),
      .sensor_start (sensor_start),
      .sensor_ready (sensor_ready),
      .sensor_error (sensor_error),
      .sensor_data  (sensor_data),
      .humidity     (humidity),
      .temperature  (temperature),
      .valid        (valid),
      .fail         (fail),
      .busy         (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Sensor responder configuration
   int          cfg_delay = 50;
   bit          cfg_err = 1'b0;
   bit          cfg_silent = 1'b0;
   logic [39:0] cfg_data = 40'h0;
   int          resp_at = -1;

   always @(negedge clk) begin
      if (rst === 1'b1 && sensor_start === 1'b1 && !cfg_silent) resp_at = cyc + cfg_delay;
   end

   always @(posedge clk) begin
      #1;
      if (cyc == resp_at) begin
         sensor_ready = 1'b1;
         sensor_error = cfg_err;
         sensor_data  = cfg_data;
         resp_at      = -1;
      end else begin
         sensor_ready = 1'b0;
         sensor_error = 1'($urandom_range(0, 1));
         sensor_data  = {8'($urandom), $urandom};
      end
   end

   // Reference model: a transaction is a start cycle s, a deciding cycle e and
   // a guard end g; everything else follows from those timestamps.
   bit          m_act = 1'b0, m_pend = 1'b0, m_retry = 1'b0, m_fail = 1'b0;
   int          m_s = 0, m_e = 0, m_g = 0, m_vcyc = -1, m_tries = 0, m_en_run = 0;
   logic [15:0] m_hum = '0, m_temp = '0;

   // Observations used by the literal checks
   int st_q[$];
   int n_valid = 0, v_last = -1, bh_last = -1;

   function automatic int att_len();
      if (cfg_silent) return TOUT;
      return (cfg_delay < TOUT) ? cfg_delay : TOUT;
   endfunction

   function automatic bit att_good();
      return !cfg_silent && !cfg_err && (cfg_delay <= TOUT);
   endfunction

   task automatic sched(input int s);
      m_s   = s;
      m_e   = s + att_len();
      m_g   = m_e + GUARD;
      m_act = 1'b1;
   endtask

   always @(negedge clk) begin : model_p
      bit trig;
      int c;
      c = cyc;
      if (rst !== 1'b1) begin
         m_act = 1'b0; m_pend = 1'b0; m_retry = 1'b0; m_fail = 1'b0;
         m_tries = 0; m_en_run = 0; m_vcyc = -1; m_hum = '0; m_temp = '0;
      end
      check("sensor_start", sensor_start, m_act && (c == m_s));
      check("busy",         busy,         m_act && (c >= m_s));
      check("valid",        valid,        c == m_vcyc);
      check("fail",         fail,         m_fail);
      check("humidity",     humidity,     m_hum);
      check("temperature",  temperature,  m_temp);
      if (sensor_start === 1'b1) st_q.push_back(c);
      if (valid === 1'b1) begin n_valid++; v_last = c; end
      if (busy === 1'b1) bh_last = c;
      if (rst === 1'b1) begin
         trig = (req === 1'b1);
         if (enable === 1'b1) begin
            if (m_en_run == PERIOD - 1) begin trig = 1'b1; m_en_run = 0; end
            else m_en_run++;
         end else begin
            m_en_run = 0;
         end
         if (trig) begin
            if (!m_act) sched(c + 1);
            else if (c >= m_s) m_pend = 1'b1;
         end
         if (m_act && c == m_e) begin
            if (att_good()) begin
               m_hum = cfg_data[39:24]; m_temp = cfg_data[23:8];
               m_vcyc = c + 1; m_fail = 1'b0; m_tries = 0; m_retry = 1'b0;
            end else if (m_tries < RETRY) begin
               m_tries++; m_retry = 1'b1;
            end else begin
               m_tries = 0; m_fail = 1'b1; m_retry = 1'b0;
            end
         end
         if (m_act && c == m_g) begin
            if (m_retry) begin m_retry = 1'b0; sched(c + 1); end
            else if (m_pend) begin m_pend = 1'b0; sched(c + 2); end
            else m_act = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_req();
      req = 1'b1;
      tick(1);
      req = 1'b0;
   endtask

   initial begin
      int b, nv, rq, c0;
      #1 rst = 1'b0;
      tick(5);
      check("rst_humidity", humidity, 16'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_start", sensor_start, 1'b0);
      check("rst_fail_valid", {fail, valid}, 2'b00);
      rst = 1'b1;
      tick(5);

      // Single good read
      cfg_delay = 50; cfg_err = 1'b0; cfg_silent = 1'b0; cfg_data = 40'h2A00170035;
      b = st_q.size(); nv = n_valid; rq = cyc;
      pulse_req();
      tick(170);
      check("t1_humidity", humidity, 16'h2A00);
      check("t1_temperature", temperature, 16'h1700);
      check("t1_valid_count", n_valid - nv, 1);
      check("t1_start_count", st_q.size() - b, 1);
      check("t1_start_latency", st_q[b] - rq, 1);
      check("t1_valid_at", v_last - st_q[b], 51);
      check("t1_busy_span", bh_last - st_q[b], 150);

      // Sensor always reports a checksum error
      cfg_err = 1'b1;
      b = st_q.size();
      pulse_req();
      tick(470);
      check("t2_start_count", st_q.size() - b, 3);
      check("t2_gap1", st_q[b + 1] - st_q[b], 151);
      check("t2_gap2", st_q[b + 2] - st_q[b + 1], 151);
      check("t2_fail_set", fail, 1'b1);
      cfg_err = 1'b0; cfg_data = 40'h1F4000E6AA;
      pulse_req();
      tick(170);
      check("t2_fail_cleared", fail, 1'b0);
      check("t2_good_humidity", humidity, 16'h1F40);

      // Sensor never answers
      cfg_silent = 1'b1;
      b = st_q.size();
      pulse_req();
      tick(920);
      check("t3_start_count", st_q.size() - b, 3);
      check("t3_gap", st_q[b + 1] - st_q[b], 301);
      check("t3_fail_set", fail, 1'b1);
      cfg_silent = 1'b0;

      // Ready on the timeout cycle wins
      cfg_delay = 200; cfg_data = 40'h31000FA011;
      b = st_q.size();
      pulse_req();
      tick(310);
      check("t4_start_count", st_q.size() - b, 1);
      check("t4_humidity", humidity, 16'h3100);
      check("t4_temperature", temperature, 16'h0FA0);
      check("t4_fail_cleared", fail, 1'b0);

      // Periodic polling plus collapsed host requests
      cfg_delay = 50; cfg_data = 40'h123456789A;
      b = st_q.size();
      enable = 1'b1; c0 = cyc;
      tick(1010);
      for (int i = 0; i < 3; i++) begin
         pulse_req();
         tick(9);
      end
      tick(3100 - (cyc - c0));
      enable = 1'b0;
      tick(200);
      check("t5_start_count", st_q.size() - b, 4);
      check("t5_first_tick", st_q[b] - c0, 1000);
      check("t5_extra_start", st_q[b + 1] - c0, 1152);
      check("t5_period2", st_q[b + 2] - c0, 2000);
      check("t5_period3", st_q[b + 3] - c0, 3000);

      // Reset during WAIT, late ready afterwards
      cfg_delay = 150; cfg_data = 40'h5500660077;
      nv = n_valid;
      pulse_req();
      tick(30);
      rst = 1'b0;
      tick(5);
      rst = 1'b1;
      tick(200);
      check("t6_valid_count", n_valid - nv, 0);
      check("t6_humidity", humidity, 16'h0);
      check("t6_temperature", temperature, 16'h0);
      check("t6_busy", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dht_poll_ctrl.md
DHT_POLL_CTRL -- requirements
Module: dht_poll_ctrl

Interface
REQ-001 Parameter PERIOD_CYC, default 200000000, auto-poll period in clk cycles (2 s at 100 MHz).
REQ-002 Parameter GUARD_CYC, default 100000000, minimum idle spacing between sensor transactions.
REQ-003 Parameter TIMEOUT_CYC, default 10000000, maximum wait for sensor_ready after sensor_start.
REQ-004 Parameter MAX_RETRY, default 3, retries after a failed attempt; range 0..7.
REQ-005 Port clk, input, 1, clock; all logic on rising edge.
REQ-006 Port rst, input, 1, reset, asynchronous, active-low.
REQ-007 Port enable, input, 1, periodic auto-poll enable.
REQ-008 Port req, input, 1, host one-shot read request, single-cycle pulse.
REQ-009 Port sensor_start, output, 1, one-cycle start pulse to the one-wire reader.
REQ-010 Port sensor_ready, input, 1, reader done strobe.
REQ-011 Port sensor_error, input, 1, reader checksum error; valid only with sensor_ready.
REQ-012 Port sensor_data, input, 40, reader frame; valid only with sensor_ready.
REQ-013 Port humidity, output, 16, last good frame bits [39:24].
REQ-014 Port temperature, output, 16, last good frame bits [23:8].
REQ-015 Port valid, output, 1, one-cycle pulse on each new good sample.
REQ-016 Port fail, output, 1, sticky: retries exhausted; cleared by next good sample.
REQ-017 Port busy, output, 1, high in every state except IDLE.

Function
REQ-018 States: IDLE, START, WAIT, GUARD; one-hot encoding.
REQ-019 Trigger = req pulse, or period counter reaching PERIOD_CYC-1 while enable=1.
- Period counter: counts while enable=1, wraps to 0 at PERIOD_CYC-1, held at 0 while enable=0.
REQ-020 A trigger arriving in any state other than IDLE sets a 1-bit pending flag; multiple triggers collapse into one.
REQ-021 IDLE -> START on trigger or pending=1; pending clears on entry to START.
REQ-022 START: sensor_start=1 for exactly one cycle; next state WAIT; timeout counter cleared.
REQ-023 WAIT: sensor_ready=1 and sensor_error=0 -> latch humidity/temperature the same edge, valid=1 next cycle, fail cleared, retry counter cleared, -> GUARD.
REQ-024 WAIT: sensor_ready=1 with sensor_error=1, or timeout counter = TIMEOUT_CYC-1 -> attempt failed, -> GUARD.
REQ-025 Failed attempt with retry counter < MAX_RETRY: retry counter increments; after GUARD, re-enter START without a trigger.
REQ-026 Failed attempt with retry counter = MAX_RETRY: fail set, retry counter cleared, no automatic restart.
REQ-027 sensor_ready arriving in IDLE, START or GUARD is ignored; outputs unchanged.
REQ-028 GUARD: counts GUARD_CYC cycles; exits to START if retry owed, else to IDLE (IDLE then honours pending the following cycle).
REQ-029 sensor_ready and timeout in the same WAIT cycle: sensor_ready takes priority.
REQ-030 Trigger in the same cycle as GUARD exit is captured in pending, not lost.
REQ-031 Deasserting enable mid-transaction does not abort; an already pending trigger is still served.
REQ-032 All counters sized by $clog2 of their parameter; no wrap beyond terminal value.

Reset
REQ-033 rst=0 forces IDLE; humidity, temperature = 0; valid, fail, busy, sensor_start, pending = 0; all counters = 0.
REQ-034 Reset mid-WAIT abandons the transaction; the first action after release is driven only by a new trigger.

Structure
REQ-035 Shared package dht_pkg holds the state encoding, the 40-bit frame field positions and the default timing constants; the reader block uses the same package.
REQ-036 One sub-module, dht_interval_timer: a loadable down-counter with a done strobe, instantiated for period, guard and timeout.

Verification (PERIOD_CYC=1000, GUARD_CYC=100, TIMEOUT_CYC=200, MAX_RETRY=2)
REQ-037 req pulse, model returns ready with error=0 and data 0x2A00170035 after 50 cycles -> humidity=0x2A00, temperature=0x1700, one valid pulse, then busy low 100 cycles later.
REQ-038 Model always returns error=1 -> exactly 3 sensor_start pulses, each pair at least 100 cycles apart, then fail=1; next good read -> fail=0.
REQ-039 Model never answers -> timeout at 200 cycles per attempt, 3 attempts, fail=1.
REQ-040 enable=1, no req -> sensor_start every 1000 cycles; three req pulses during one WAIT -> exactly one extra transaction.
REQ-041 rst low mid-WAIT, then a late sensor_ready -> no valid pulse, outputs stay 0, state IDLE.
REQ-042 sensor_ready and timeout in the same cycle with error=0 -> good sample latched, no retry.
